// File: rtl/tpu_loader_pkg.sv
// Shared types and header field layout for the host memory loader.
package tpu_loader_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      RD_ISSUE = 2'd2,
      RD_HOLD  = 2'd3
   } state_t;

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;

   localparam int HDR_LEN_LSB  = 16;
   localparam int HDR_LEN_MSB  = 23;
   localparam int HDR_ADDR_MSB = 15;
   localparam int LEN_W        = HDR_LEN_MSB - HDR_LEN_LSB + 1;

   // Base field bits at or above the address width must be zero for a legal header.
   function automatic logic base_out_of_range(input logic [HDR_ADDR_MSB:0] field,
                                              input int addr_w);
      return (field >> addr_w) != '0;
   endfunction

endpackage

// File: rtl/loader_addr_ctr.sv
// Word address / remaining-length counter pair; address wraps modulo 2^ADDR_W.
module loader_addr_ctr #(
   parameter int ADDR_W = 6,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] base,
   input  logic [LEN_W-1:0]  len_m1,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [LEN_W-1:0] remain;

   always_ff @(posedge clk) begin
      if (!reset) begin
         addr   <= '0;
         remain <= '0;
      end else if (load) begin
         addr   <= base;
         remain <= len_m1;
      end else if (step) begin
         addr   <= addr + ADDR_W'(1);
         remain <= remain - LEN_W'(1);
      end
   end

   assign last = (remain == '0);

endmodule

// File: rtl/host_mem_loader.sv
// Host stream to unified-memory loader: header-driven burst writes and reads.
// Optional LOADER_CHECKSUM_EN adds a csum output summing words written since the last header.
module host_mem_loader
   import tpu_loader_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              err
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] csum
`endif
);

   state_t            state, state_nxt;
   logic              ctr_load, ctr_step, ctr_last;
   logic [ADDR_W-1:0] ctr_addr;
   logic              done_nxt, err_set, hdr_acc;
   logic              rd_pend;
   logic              hdr_op, hdr_bad;
   logic [LEN_W-1:0]  hdr_len_m1;

   assign hdr_op     = s_data[DATA_W-1];
   assign hdr_len_m1 = s_data[HDR_LEN_MSB:HDR_LEN_LSB];
   assign hdr_bad    = base_out_of_range(s_data[HDR_ADDR_MSB:0], ADDR_W);

   loader_addr_ctr #(
      .ADDR_W(ADDR_W),
      .LEN_W (LEN_W)
   ) u_ctr (
      .clk   (clk),
      .reset (reset),
      .load  (ctr_load),
      .step  (ctr_step),
      .base  (s_data[ADDR_W-1:0]),
      .len_m1(hdr_len_m1),
      .addr  (ctr_addr),
      .last  (ctr_last)
   );

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      busy      = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = ctr_addr;
      mem_wdata = s_data;
      ctr_load  = 1'b0;
      ctr_step  = 1'b0;
      done_nxt  = 1'b0;
      err_set   = 1'b0;
      hdr_acc   = 1'b0;
      // Every strobe is gated off while reset is held low.
      if (reset) begin
         busy = (state != IDLE);
         case (state)
            IDLE: begin
               s_ready = 1'b1;
               if (s_valid) begin
                  hdr_acc = 1'b1;
                  if (hdr_bad) begin
                     err_set = 1'b1;
                  end else begin
                     ctr_load  = 1'b1;
                     state_nxt = (hdr_op == OP_READ) ? RD_ISSUE : WRITE;
                  end
               end
            end
            WRITE: begin
               s_ready = 1'b1;
               if (s_valid) begin
                  mem_we   = 1'b1;
                  ctr_step = 1'b1;
                  if (ctr_last) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end
            RD_ISSUE: begin
               mem_re    = 1'b1;
               state_nxt = RD_HOLD;
            end
            RD_HOLD: begin
               if (m_valid && m_ready) begin
                  ctr_step = 1'b1;
                  if (ctr_last) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = RD_ISSUE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Read data arrives the cycle after mem_re; it is captured then and held until taken.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         m_valid <= 1'b0;
         m_data  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         rd_pend <= 1'b0;
      end else begin
         state   <= state_nxt;
         done    <= done_nxt;
         rd_pend <= mem_re;
         if (err_set) begin
            err <= 1'b1;
         end
         if (rd_pend) begin
            m_data  <= mem_rdata;
            m_valid <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         csum <= '0;
      end else if (hdr_acc) begin
         csum <= '0;
      end else if (mem_we) begin
         csum <= csum + mem_wdata;
      end
   end
`endif

endmodule

// File: tb/tb_host_mem_loader.sv
// Randomized self-checking bench for host_mem_loader against a word-level memory model.
module tb_host_mem_loader;

   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          s_valid, s_ready, m_valid, m_ready;
   logic [DW-1:0] s_data, m_data, mem_wdata, mem_rdata;
   logic          mem_we, mem_re, busy, done, err;
   logic [AW-1:0] mem_addr;
`ifdef LOADER_CHECKSUM_EN
   logic [DW-1:0] csum;
`endif

   int total = 0;
   int bad   = 0;
   int we_cnt = 0, done_cnt = 0, overlap_cnt = 0;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];

   host_mem_loader #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .mem_we   (mem_we),
      .mem_re   (mem_re),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .done     (done),
      .err      (err)
`ifdef LOADER_CHECKSUM_EN
      ,
      .csum     (csum)
`endif
   );

   always #5 clk = ~clk;

   // Unified memory with one-cycle read latency, plus event counters.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) we_cnt <= we_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (mem_we && mem_re) overlap_cnt <= overlap_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] hdr(input bit op, input int len, input int base);
      return {op, 7'($urandom), 8'(len - 1), 16'(base)};
   endfunction

   task automatic check_image(input string tag);
      int diffs = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check(tag, diffs, 0);
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   // Present one word; returns at the negedge following its handshake.
   task automatic send(input logic [DW-1:0] d);
      int n = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         check("send_timeout", 0, 1);
         s_valid = 1'b0;
         return;
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = $urandom;
   endtask

   // mode 0: random data, 1: 0xA+i, 2: 1+i
   task automatic do_write(input int base, input int len, input int mode);
      int w0 = we_cnt;
      int d0 = done_cnt;
      logic [DW-1:0] d, sum;
      sum = '0;
      send(hdr(1'b0, len, base));
`ifdef LOADER_CHECKSUM_EN
      check("csum_clear", csum, 0);
`endif
      for (int i = 0; i < len; i++) begin
         d = (mode == 1) ? DW'(32'hA + i) : (mode == 2) ? DW'(1 + i) : DW'($urandom);
         ref_mem[(base + i) % DEPTH] = d;
         sum += d;
         if (i > 0) gap();
         send(d);
      end
      check("wr_done_pulse", done, 1);
      check("wr_busy_after", busy, 0);
`ifdef LOADER_CHECKSUM_EN
      check("csum_sum", csum, sum);
`endif
      @(negedge clk);
      check("wr_done_low", done, 0);
      check("wr_we_cnt", we_cnt - w0, len);
      check("wr_done_cnt", done_cnt - d0, 1);
      check_image("wr_mem_image");
   endtask

   task automatic do_read(input int base, input int len, input bit toggle);
      int w0 = we_cnt;
      int d0 = done_cnt;
      logic [DW-1:0] held_val;
      bit held, got;
      int n;
      send(hdr(1'b1, len, base));
      m_ready = 1'b0;
      for (int i = 0; i < len; i++) begin
         held = 0;
         got  = 0;
         n    = 0;
         while (!got && n < 200) begin
            s_valid = $urandom_range(0, 1);
            m_ready = toggle ? ~m_ready : 1'($urandom_range(0, 1));
            if (m_valid) begin
               check("rd_sready_low", s_ready, 0);
               if (held) check("rd_hold_stable", m_data, held_val);
               if (m_ready) begin
                  check("rd_data", m_data, ref_mem[(base + i) % DEPTH]);
                  got = 1;
               end else begin
                  held     = 1;
                  held_val = m_data;
               end
            end
            @(negedge clk);
            n++;
         end
         if (!got) begin
            check("rd_timeout", 0, 1);
            s_valid = 1'b0;
            m_ready = 1'b0;
            return;
         end
      end
      s_valid = 1'b0;
      m_ready = 1'b0;
      check("rd_done_pulse", done, 1);
      @(negedge clk);
      check("rd_busy_after", busy, 0);
      check("rd_no_write", we_cnt - w0, 0);
      check("rd_done_cnt", done_cnt - d0, 1);
   endtask

   initial begin
      int w0, d0, base, len;
      reset   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_sready", s_ready, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_mvalid", m_valid, 0);
      check("rst_mdata", m_data, 0);
      check("rst_we_re", {mem_we, mem_re}, 0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_sready", s_ready, 1);

      do_write(0, DEPTH, 0);
      do_write(5, 3, 1);
      do_read(5, 3, 1);
      do_write(62, 4, 0);
      do_read(62, 4, 0);

      // Out-of-range base: flagged, nothing transferred.
      w0 = we_cnt;
      d0 = done_cnt;
      send(hdr(1'b0, 4, 70));
      @(negedge clk);
      check("err_set", err, 1);
      check("err_busy", busy, 0);
      check("err_no_we", we_cnt - w0, 0);
      check("err_no_done", done_cnt - d0, 0);
      do_write(10, 2, 0);
      check("err_sticky", err, 1);

      // Reset in the middle of a four-word write.
      w0 = we_cnt;
      d0 = done_cnt;
      send(hdr(1'b0, 4, 20));
      for (int i = 0; i < 2; i++) begin
         ref_mem[20 + i] = $urandom;
         send(ref_mem[20 + i]);
      end
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_sready", s_ready, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_idle", busy, 0);
      check("mid_rst_err_clr", err, 0);
      check("mid_rst_we_cnt", we_cnt - w0, 2);
      check("mid_rst_no_done", done_cnt - d0, 0);
      check_image("mid_rst_image");

`ifdef LOADER_CHECKSUM_EN
      do_write(30, 3, 2);
      check("csum_six", csum, 6);
      send(hdr(1'b0, 1, 40));
      check("csum_new_hdr", csum, 0);
      ref_mem[40] = 32'h5;
      send(32'h5);
      @(negedge clk);
`endif

      for (int k = 0; k < 24; k++) begin
         base = $urandom_range(0, DEPTH - 1);
         len  = $urandom_range(1, 16);
         if ($urandom_range(0, 1) == 1) do_read(base, len, 0);
         else do_write(base, len, 0);
         gap();
      end
      do_write($urandom_range(0, DEPTH - 1), 256, 0);
      do_read(0, DEPTH, 0);

      check("we_re_exclusive", overlap_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
